// File: rtl/hart_status_ctrl_if.sv
// APB signal bundle for the hart status/control block.
interface hart_status_ctrl_if;
  logic       PSEL;
  logic       PENABLE;
  logic       PWRITE;
  logic [7:0] PADDR;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA;
  logic       PREADY;
  logic       PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/hart_status_ctrl.sv
// Debug/reset control for a hart cluster: debug requests, reset pulses,
// sticky halt-event flags and a maskable halt interrupt over APB.
module hart_status_ctrl #(
  parameter int unsigned NUM_HARTS          = 2,
  parameter int unsigned RESET_PULSE_CYCLES = 3,
  parameter bit          DEBUG_AUTO_CLEAR   = 1'b1
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  hart_status_ctrl_if.slave    apb,
  output logic [NUM_HARTS-1:0] DEBUG_REQUEST,
  input  logic [NUM_HARTS-1:0] DEBUG_ACK,
  output logic [NUM_HARTS-1:0] RESET_REQUEST,
  input  logic [NUM_HARTS-1:0] HALTED,
  output logic                 IRQ
);

  localparam int unsigned CW = $clog2(RESET_PULSE_CYCLES + 1);

  localparam logic [7:0] ADDR_DBG_REQ  = 8'h00;
  localparam logic [7:0] ADDR_DBG_CLR  = 8'h01;
  localparam logic [7:0] ADDR_RST      = 8'h02;
  localparam logic [7:0] ADDR_ACK      = 8'h03;
  localparam logic [7:0] ADDR_HALT     = 8'h04;
  localparam logic [7:0] ADDR_HALT_EVT = 8'h05;
  localparam logic [7:0] ADDR_IRQ_EN   = 8'h06;

  logic                 acc, wr, mapped;
  logic [NUM_HARTS-1:0] wdata, rdata_h;
  logic [NUM_HARTS-1:0] dbg_q, ack_q, halt_q, evt_q, irq_en_q;
  logic [NUM_HARTS-1:0] dbg_set, dbg_clr, ack_rise, rst_set, evt_clr;
  logic [NUM_HARTS-1:0] dbg_next, evt_next;
  logic [CW-1:0]        cnt [NUM_HARTS];
  logic                 unused_ok;

  assign acc       = apb.PSEL & apb.PENABLE;
  assign wr        = acc & apb.PWRITE;
  assign wdata     = apb.PWDATA[NUM_HARTS-1:0];
  assign unused_ok = ^apb.PWDATA;

  assign dbg_set  = (wr && apb.PADDR == ADDR_DBG_REQ)  ? wdata : '0;
  assign dbg_clr  = (wr && apb.PADDR == ADDR_DBG_CLR)  ? wdata : '0;
  assign rst_set  = (wr && apb.PADDR == ADDR_RST)      ? wdata : '0;
  assign evt_clr  = (wr && apb.PADDR == ADDR_HALT_EVT) ? wdata : '0;
  assign ack_rise = DEBUG_AUTO_CLEAR ? (DEBUG_ACK & ~ack_q) : '0;

  // Set terms are OR-ed last so a same-cycle W1S / rising HALTED wins over clears.
  assign dbg_next = (dbg_q & ~dbg_clr & ~ack_rise) | dbg_set;
  assign evt_next = (evt_q & ~evt_clr) | (HALTED & ~halt_q);

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      dbg_q    <= '0;
      ack_q    <= '0;
      halt_q   <= '0;
      evt_q    <= '0;
      irq_en_q <= '0;
      for (int unsigned i = 0; i < NUM_HARTS; i++) cnt[i] <= '0;
    end else begin
      dbg_q  <= dbg_next;
      ack_q  <= DEBUG_ACK;
      halt_q <= HALTED;
      evt_q  <= evt_next;
      if (wr && apb.PADDR == ADDR_IRQ_EN) irq_en_q <= wdata;
      for (int unsigned i = 0; i < NUM_HARTS; i++) begin
        if (rst_set[i])      cnt[i] <= CW'(RESET_PULSE_CYCLES);
        else if (cnt[i] != '0) cnt[i] <= cnt[i] - CW'(1);
      end
    end
  end

  always_comb begin
    RESET_REQUEST = '0;
    for (int unsigned i = 0; i < NUM_HARTS; i++) RESET_REQUEST[i] = (cnt[i] != '0);
  end

  assign DEBUG_REQUEST = dbg_q;
  assign IRQ           = |(evt_q & irq_en_q);

  always_comb begin
    rdata_h = '0;
    mapped  = 1'b1;
    case (apb.PADDR)
      ADDR_DBG_REQ, ADDR_DBG_CLR: rdata_h = dbg_q;
      ADDR_RST:                   rdata_h = RESET_REQUEST;
      ADDR_ACK:                   rdata_h = DEBUG_ACK;
      ADDR_HALT:                  rdata_h = HALTED;
      ADDR_HALT_EVT:              rdata_h = evt_q;
      ADDR_IRQ_EN:                rdata_h = irq_en_q;
      default:                    mapped  = 1'b0;
    endcase
  end

  always_comb begin
    apb.PRDATA = '0;
    if (acc) apb.PRDATA[NUM_HARTS-1:0] = rdata_h;
  end

  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = acc & ~mapped;

endmodule

// File: tb/tb_hart_status_ctrl.sv
// Directed bench for hart_status_ctrl: register-map vector table plus
// hand-written sequences for debug handshake, reset pulses, halt events and reset.
module tb_hart_status_ctrl;

  logic       PCLK = 1'b0;
  logic       PRESET;
  logic [1:0] DEBUG_REQUEST, DEBUG_ACK, RESET_REQUEST, HALTED;
  logic       IRQ;

  hart_status_ctrl_if bus();

  hart_status_ctrl #(
    .NUM_HARTS(2),
    .RESET_PULSE_CYCLES(3),
    .DEBUG_AUTO_CLEAR(1'b1)
  ) dut (
    .PCLK(PCLK),
    .PRESET(PRESET),
    .apb(bus.slave),
    .DEBUG_REQUEST(DEBUG_REQUEST),
    .DEBUG_ACK(DEBUG_ACK),
    .RESET_REQUEST(RESET_REQUEST),
    .HALTED(HALTED),
    .IRQ(IRQ)
  );

  always #5 PCLK = ~PCLK;

  int total = 0;
  int bad   = 0;

  logic       side_en;
  logic [1:0] side_ack, side_halt;

  int   hi0;
  logic hart1_seen;

  always @(negedge PCLK) begin
    if (RESET_REQUEST[0] === 1'b1) hi0++;
    if (RESET_REQUEST[1] !== 1'b0) hart1_seen = 1'b1;
  end

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       err;
    logic [1:0] dreq;
  } vec_t;

  vec_t vecs [18];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  // Called just after a falling edge; returns just after the falling edge
  // that follows the register-update rising edge.
  task automatic apb_xfer(input logic w, input logic [7:0] a, input logic [7:0] d,
                          output logic [7:0] rd, output logic err);
    bus.PSEL    = 1'b1;
    bus.PWRITE  = w;
    bus.PADDR   = a;
    bus.PWDATA  = d;
    bus.PENABLE = 1'b0;
    @(negedge PCLK);
    bus.PENABLE = 1'b1;
    if (side_en) begin
      DEBUG_ACK = side_ack;
      HALTED    = side_halt;
      side_en   = 1'b0;
    end
    #1;
    rd  = bus.PRDATA;
    err = bus.PSLVERR;
    @(negedge PCLK);
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    logic [7:0] rd;
    logic       err;
    apb_xfer(1'b1, a, d, rd, err);
    check($sformatf("wr_err_%02h", a), {7'd0, err}, 8'h00);
  endtask

  task automatic rd_chk(input string name, input logic [7:0] a, input logic [7:0] exp);
    logic [7:0] rd;
    logic       err;
    apb_xfer(1'b0, a, 8'h00, rd, err);
    check(name, rd, exp);
  endtask

  initial begin
    logic [7:0] rd;
    logic       err;

    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    bus.PADDR = '0;  bus.PWDATA = '0;
    DEBUG_ACK = '0; HALTED = '0; side_en = 1'b0; side_ack = '0; side_halt = '0;
    hi0 = 0; hart1_seen = 1'b0;
    PRESET = 1'b1;

    //       wr    addr   wdata  rdata  err   dreq
    vecs[0]  = '{1'b1, 8'h00, 8'hFF, 8'h00, 1'b0, 2'b11};
    vecs[1]  = '{1'b0, 8'h00, 8'h00, 8'h03, 1'b0, 2'b11};
    vecs[2]  = '{1'b0, 8'h01, 8'h00, 8'h03, 1'b0, 2'b11};
    vecs[3]  = '{1'b1, 8'h01, 8'h01, 8'h00, 1'b0, 2'b10};
    vecs[4]  = '{1'b0, 8'h00, 8'h00, 8'h02, 1'b0, 2'b10};
    vecs[5]  = '{1'b1, 8'h06, 8'hFE, 8'h00, 1'b0, 2'b10};
    vecs[6]  = '{1'b0, 8'h06, 8'h00, 8'h02, 1'b0, 2'b10};
    vecs[7]  = '{1'b0, 8'h05, 8'h00, 8'h00, 1'b0, 2'b10};
    vecs[8]  = '{1'b0, 8'h04, 8'h00, 8'h00, 1'b0, 2'b10};
    vecs[9]  = '{1'b0, 8'h03, 8'h00, 8'h00, 1'b0, 2'b10};
    vecs[10] = '{1'b1, 8'h07, 8'hFF, 8'h00, 1'b1, 2'b10};
    vecs[11] = '{1'b0, 8'h07, 8'h00, 8'h00, 1'b1, 2'b10};
    vecs[12] = '{1'b0, 8'h00, 8'h00, 8'h02, 1'b0, 2'b10};
    vecs[13] = '{1'b0, 8'h06, 8'h00, 8'h02, 1'b0, 2'b10};
    vecs[14] = '{1'b0, 8'h80, 8'h00, 8'h00, 1'b1, 2'b10};
    vecs[15] = '{1'b1, 8'h01, 8'hFF, 8'h00, 1'b0, 2'b00};
    vecs[16] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 2'b00};
    vecs[17] = '{1'b0, 8'h02, 8'h00, 8'h00, 1'b0, 2'b00};

    // Reset state
    repeat (2) @(negedge PCLK);
    check("rst_dreq",    {6'd0, DEBUG_REQUEST}, 8'h00);
    check("rst_rreq",    {6'd0, RESET_REQUEST}, 8'h00);
    check("rst_irq",     {7'd0, IRQ},           8'h00);
    check("rst_prdata",  bus.PRDATA,            8'h00);
    check("rst_pslverr", {7'd0, bus.PSLVERR},   8'h00);
    check("rst_pready",  {7'd0, bus.PREADY},    8'h01);
    PRESET = 1'b0;
    @(negedge PCLK);

    // Register map vectors
    for (int i = 0; i < 18; i++) begin
      apb_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, err);
      if (!vecs[i].wr) check($sformatf("vec%0d_rdata", i), rd, vecs[i].rdata);
      check($sformatf("vec%0d_err", i),  {7'd0, err}, {7'd0, vecs[i].err});
      check($sformatf("vec%0d_dreq", i), {6'd0, DEBUG_REQUEST}, {6'd0, vecs[i].dreq});
    end

    // Debug handshake with auto-clear
    wr(8'h00, 8'h03);
    rd_chk("dbg_rd_set", 8'h00, 8'h03);
    DEBUG_ACK = 2'b01;
    #1 check("dbg_ack_no_comb", {6'd0, DEBUG_REQUEST}, 8'h03);
    @(negedge PCLK);
    check("dbg_ack_clear0", {6'd0, DEBUG_REQUEST}, 8'h02);
    wr(8'h00, 8'h01);
    check("dbg_ack_held_no_clear", {6'd0, DEBUG_REQUEST}, 8'h03);
    DEBUG_ACK = 2'b00;
    wr(8'h01, 8'h01);
    check("dbg_w1c", {6'd0, DEBUG_REQUEST}, 8'h02);
    side_en = 1'b1; side_ack = 2'b01; side_halt = 2'b00;
    wr(8'h00, 8'h01);
    check("dbg_w1s_wins", {6'd0, DEBUG_REQUEST}, 8'h03);
    @(negedge PCLK);
    check("dbg_w1s_wins_hold", {6'd0, DEBUG_REQUEST}, 8'h03);
    DEBUG_ACK = 2'b00;
    wr(8'h01, 8'h03);
    check("dbg_w1c_all", {6'd0, DEBUG_REQUEST}, 8'h00);
    wr(8'h00, 8'h02);
    DEBUG_ACK = 2'b10;
    @(negedge PCLK);
    check("dbg_ack_clear1", {6'd0, DEBUG_REQUEST}, 8'h00);
    DEBUG_ACK = 2'b00;
    @(negedge PCLK);

    // Reset pulse length and extension
    hi0 = 0; hart1_seen = 1'b0;
    wr(8'h02, 8'h01);
    check("rst_pulse_start", {6'd0, RESET_REQUEST}, 8'h01);
    rd_chk("rst_rd_active", 8'h02, 8'h01);
    repeat (5) @(negedge PCLK);
    check("rst_pulse_len3", 8'(hi0), 8'd3);
    hi0 = 0;
    wr(8'h02, 8'h01);
    wr(8'h02, 8'h01);
    repeat (6) @(negedge PCLK);
    check("rst_pulse_len5", 8'(hi0), 8'd5);
    check("rst_hart1_idle", {7'd0, hart1_seen}, 8'h00);
    check("rst_pulse_end", {6'd0, RESET_REQUEST}, 8'h00);

    // Halt events and IRQ (IRQ_EN = 0x02 from the vector table)
    HALTED = 2'b10;
    #1 check("halt_irq_no_comb", {7'd0, IRQ}, 8'h00);
    @(negedge PCLK);
    check("halt_irq_set", {7'd0, IRQ}, 8'h01);
    rd_chk("halt_evt_rd", 8'h05, 8'h02);
    rd_chk("halt_rd", 8'h04, 8'h02);
    wr(8'h05, 8'h02);
    check("halt_w1c_irq", {7'd0, IRQ}, 8'h00);
    rd_chk("halt_evt_cleared", 8'h05, 8'h00);
    HALTED = 2'b00;
    @(negedge PCLK);
    side_en = 1'b1; side_ack = 2'b00; side_halt = 2'b10;
    wr(8'h05, 8'h02);
    rd_chk("halt_set_wins", 8'h05, 8'h02);
    check("halt_set_wins_irq", {7'd0, IRQ}, 8'h01);
    HALTED = 2'b11;
    @(negedge PCLK);
    rd_chk("halt_evt_both", 8'h05, 8'h03);
    wr(8'h05, 8'h02);
    check("halt_irq_masked", {7'd0, IRQ}, 8'h00);
    rd_chk("halt_evt_bit0", 8'h05, 8'h01);
    wr(8'h06, 8'h01);
    check("halt_irq_en0", {7'd0, IRQ}, 8'h01);
    wr(8'h06, 8'h00);
    check("halt_irq_dis", {7'd0, IRQ}, 8'h00);
    wr(8'h05, 8'h03);
    HALTED = 2'b01;

    // Asynchronous reset in the middle of a pulse with requests pending
    wr(8'h00, 8'h03);
    wr(8'h02, 8'h03);
    check("pre_reset_rreq", {6'd0, RESET_REQUEST}, 8'h03);
    #2 PRESET = 1'b1;
    #1;
    check("async_dreq", {6'd0, DEBUG_REQUEST}, 8'h00);
    check("async_rreq", {6'd0, RESET_REQUEST}, 8'h00);
    check("async_irq",  {7'd0, IRQ},           8'h00);
    @(negedge PCLK);
    PRESET = 1'b0;
    rd_chk("post_reset_rst", 8'h02, 8'h00);
    rd_chk("post_reset_dbg", 8'h00, 8'h00);
    rd_chk("post_reset_halted_evt", 8'h05, 8'h01);
    rd_chk("post_reset_irq_en", 8'h06, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hart_status_ctrl.md
# hart_status_ctrl

APB-attached debug and reset control block for a cluster of up to eight harts, the multi-hart, parametrised successor of the single-hart status register. It provides per-hart debug requests (set, clear, and optional auto-clear on acknowledge), per-hart reset pulses of programmable length, sticky halt-event flags with W1C clear, and a maskable interrupt. It sits on the debug APB segment between the host bridge and the hart cluster.

## Interface
Parameters:
- NUM_HARTS, 2: number of harts; legal range 1..8; each register uses bits [NUM_HARTS-1:0].
- RESET_PULSE_CYCLES, 3: length of each RESET_REQUEST pulse in PCLK cycles; legal range 1..255.
- DEBUG_AUTO_CLEAR, 1: 1 = a debug request clears itself on a rising DEBUG_ACK; 0 = it stays set until software clears it.

Ports:
- PCLK  in  1  clock.
- PRESET  in  1  asynchronous, active-high reset.
- PSEL, PENABLE, PWRITE  in  1 each  APB control.
- PADDR  in  8  register address.
- PWDATA  in  8  write data.
- PRDATA  out  8  read data.
- PREADY  out  1  tied to 1; no wait states.
- PSLVERR  out  1  access to an unmapped address.
- DEBUG_REQUEST  out  NUM_HARTS  per-hart debug request.
- DEBUG_ACK  in  NUM_HARTS  per-hart acknowledge, synchronous to PCLK.
- RESET_REQUEST  out  NUM_HARTS  per-hart reset pulse.
- HALTED  in  NUM_HARTS  per-hart halted status, synchronous to PCLK.
- IRQ  out  1  halt-event interrupt.

## Operation
- Access strobe: `acc = PSEL & PENABLE`. Write strobe: `wr = acc & PWRITE`. One effect per transfer.
- Register map (bits above NUM_HARTS-1 read 0, writes to them are ignored):
  - 0x00 DBG_REQ, RW/W1S: writing 1 sets the request bit; reads return DEBUG_REQUEST.
  - 0x01 DBG_CLR, W1C: writing 1 clears the request bit; reads return DEBUG_REQUEST.
  - 0x02 RST, W1S: writing 1 starts or restarts the pulse; reads return RESET_REQUEST.
  - 0x03 ACK, RO: DEBUG_ACK.
  - 0x04 HALT, RO: HALTED.
  - 0x05 HALT_EVT, W1C: sticky flags.
  - 0x06 IRQ_EN, RW.
- Unmapped address: PRDATA=0, write ignored, PSLVERR=acc. On mapped addresses PSLVERR=0.
- Debug auto-clear (DEBUG_AUTO_CLEAR=1): keep a registered copy of DEBUG_ACK. A rising DEBUG_ACK on hart i clears request bit i. A same-cycle W1S to bit i wins, and the bit stays set.
- Reset pulse: each hart has a counter of width clog2(RESET_PULSE_CYCLES+1).
  - A W1S loads the counter with RESET_PULSE_CYCLES; otherwise a nonzero counter decrements.
  - RESET_REQUEST[i] = (cnt_i != 0).
  - A write during an active pulse reloads the counter, extending the pulse; there is no wrap.
- Halt events: keep a registered copy of HALTED, reset value 0. A rising HALTED sets HALT_EVT[i].
  - A set and a W1C in the same cycle: set wins.
  - A hart already halted at reset release logs an event on the first clock.
- IRQ = |(HALT_EVT & IRQ_EN), combinational from registers.
- PRDATA is combinational from current state, gated by acc, and 0 otherwise.

## Timing
- Reset values: DEBUG_REQUEST=0, RESET_REQUEST=0, IRQ=0, PRDATA=0, PSLVERR=0, PREADY=1. All counters, flags, IRQ_EN and the registered input copies are 0.
- PRESET asserted mid-pulse or mid-transfer: all outputs drop immediately (asynchronous). No pending effect survives.
- Write latency: a register changes on the PCLK edge ending the access cycle, and its output is visible one cycle later.
- RESET_REQUEST is high for exactly RESET_PULSE_CYCLES cycles after the write edge, per hart and independently.
- Input edge detection adds 1 cycle: HALTED rising at edge N sets HALT_EVT and IRQ after edge N+1. DEBUG_ACK to request-clear has the same latency.
- Reads return values as of the access cycle; a write and a read in the same transfer are impossible.

## Test plan
- Reset: assert PRESET mid-reset-pulse with DBG_REQ=0x3. All outputs go to 0 without waiting for a clock edge. After release, a read of 0x02 returns 0x00.
- Debug handshake (NUM_HARTS=2, AUTO_CLEAR=1): write 0x00←0x03 and read 0x00 → 0x03. Raise DEBUG_ACK[0] → DEBUG_REQUEST=0x2 one cycle later. Write 0x01←0x02 → DEBUG_REQUEST=0x0.
- Reset pulse (RESET_PULSE_CYCLES=3): write 0x02←0x01 → RESET_REQUEST[0] high for exactly 3 cycles. Rewrite at pulse cycle 2 → the pulse lasts 2+3=5 cycles in total. Hart 1 stays 0 throughout.
- Halt event and IRQ: IRQ_EN←0x02, then raise HALTED[1] → HALT_EVT reads 0x02 and IRQ=1. Write 0x05←0x02 → IRQ=0. Rising HALTED[1] in the same cycle as a W1C → flag stays 1.
- Unmapped access: write 0x07←0xFF → PSLVERR=1 in the access cycle and no state changes. A read of 0x07 returns 0x00 with PSLVERR=1.
- Width masking (NUM_HARTS=2): write 0x00←0xFF → DBG_REQ reads 0x03. Reads of unimplemented bits 7:2 are 0 in every register.
